// File: rtl/iob_uart_csr_arb_pkg.sv
// ============================================================================
// Module   : iob_uart_csr_arb_pkg
// Brief    : Shared FSM encodings and master indices for the UART CSR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_uart_csr_arb_pkg;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FWD    = 2'd1;
    localparam logic [1:0] c_WAIT_R = 2'd2;

    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/iob_uart_csr_arb_pick2.sv
// ============================================================================
// Module   : iob_rr_pick2
// Brief    : Combinational two-way round-robin picker (prio breaks ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_rr_pick2
    import iob_uart_csr_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic       gnt_idx_o,
    output logic       any_o
);

    always_comb begin
        any_o = |req_i;
        if (req_i == 2'b11) begin
            gnt_idx_o = prio_i;
        end else if (req_i[1]) begin
            gnt_idx_o = c_M1;
        end else begin
            gnt_idx_o = c_M0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_uart_csr_arb.sv
// ============================================================================
// Module   : iob_uart_csr_arb
// Brief    : Round-robin arbiter sharing one iob CSR bus between two masters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_uart_csr_arb
    import iob_uart_csr_arb_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,

    input  logic                m0_iob_valid_i,
    input  logic [ADDR_W-1:0]   m0_iob_addr_i,
    input  logic [DATA_W-1:0]   m0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
    output logic                m0_iob_ready_o,
    output logic                m0_iob_rvalid_o,
    output logic [DATA_W-1:0]   m0_iob_rdata_o,

    input  logic                m1_iob_valid_i,
    input  logic [ADDR_W-1:0]   m1_iob_addr_i,
    input  logic [DATA_W-1:0]   m1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
    output logic                m1_iob_ready_o,
    output logic                m1_iob_rvalid_o,
    output logic [DATA_W-1:0]   m1_iob_rdata_o,

    output logic                s_iob_valid_o,
    output logic [ADDR_W-1:0]   s_iob_addr_o,
    output logic [DATA_W-1:0]   s_iob_wdata_o,
    output logic [DATA_W/8-1:0] s_iob_wstrb_o,
    input  logic                s_iob_ready_i,
    input  logic                s_iob_rvalid_i,
    input  logic [DATA_W-1:0]   s_iob_rdata_i
);

    logic [1:0]          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                prio_q, prio_d;

    logic                w_pick_idx;
    logic                w_pick_any;
    logic                w_req_valid;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [DATA_W-1:0]   w_req_wdata;
    logic [DATA_W/8-1:0] w_req_wstrb;
    logic                w_fwd;
    logic                w_is_read;
    logic                w_accept;
    logic                w_rsp_en;

    iob_rr_pick2 u_pick (
        .req_i     ({m1_iob_valid_i, m0_iob_valid_i}),
        .prio_i    (prio_q),
        .gnt_idx_o (w_pick_idx),
        .any_o     (w_pick_any)
    );

    always_comb begin
        if (gnt_q == c_M1) begin
            w_req_valid = m1_iob_valid_i;
            w_req_addr  = m1_iob_addr_i;
            w_req_wdata = m1_iob_wdata_i;
            w_req_wstrb = m1_iob_wstrb_i;
        end else begin
            w_req_valid = m0_iob_valid_i;
            w_req_addr  = m0_iob_addr_i;
            w_req_wdata = m0_iob_wdata_i;
            w_req_wstrb = m0_iob_wstrb_i;
        end
    end

    assign w_fwd     = (state_q == c_FWD);
    assign w_is_read = (w_req_wstrb == '0);
    assign w_accept  = w_fwd & w_req_valid & s_iob_ready_i;
    // A read accepted in FWD may already see its response in the same cycle.
    assign w_rsp_en  = (state_q == c_WAIT_R) | (w_accept & w_is_read);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        case (state_q)
            c_IDLE: begin
                if (w_pick_any) begin
                    state_d = c_FWD;
                    gnt_d   = w_pick_idx;
                end
            end
            c_FWD: begin
                if (!w_req_valid) begin
                    state_d = c_IDLE;
                end else if (s_iob_ready_i) begin
                    if (!w_is_read || s_iob_rvalid_i) begin
                        state_d = c_IDLE;
                        prio_d  = ~prio_q;
                    end else begin
                        state_d = c_WAIT_R;
                    end
                end
            end
            c_WAIT_R: begin
                if (s_iob_rvalid_i) begin
                    state_d = c_IDLE;
                    prio_d  = ~prio_q;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= c_IDLE;
            gnt_q   <= c_M0;
            prio_q  <= c_M0;
        end else if (cke_i) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    assign s_iob_valid_o   = w_fwd & w_req_valid;
    assign s_iob_addr_o    = w_fwd ? w_req_addr  : '0;
    assign s_iob_wdata_o   = w_fwd ? w_req_wdata : '0;
    assign s_iob_wstrb_o   = w_fwd ? w_req_wstrb : '0;

    assign m0_iob_ready_o  = w_fwd & (gnt_q == c_M0) & s_iob_ready_i;
    assign m1_iob_ready_o  = w_fwd & (gnt_q == c_M1) & s_iob_ready_i;
    assign m0_iob_rvalid_o = w_rsp_en & (gnt_q == c_M0) & s_iob_rvalid_i;
    assign m1_iob_rvalid_o = w_rsp_en & (gnt_q == c_M1) & s_iob_rvalid_i;
    assign m0_iob_rdata_o  = (w_rsp_en && gnt_q == c_M0) ? s_iob_rdata_i : '0;
    assign m1_iob_rdata_o  = (w_rsp_en && gnt_q == c_M1) ? s_iob_rdata_i : '0;

endmodule

`default_nettype wire
